// File: rtl/line_avg_pkg.sv
// Shared constants and helpers for the streaming vertical line averager.
// Rounding mode selectors and the counter width function live here.
package line_avg_pkg;

  localparam int RND_TRUNC   = 0;
  localparam int RND_HALF_UP = 1;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_avg_buf.sv
// Single-line pixel history: combinational read and synchronous write at the
// same address, so a read in the write cycle returns the previous row's pixel.
module line_avg_buf #(
  parameter int DATA_W = 8,
  parameter int COLS   = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [COLS];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/line_avg_stream.sv
// Streaming vertical averager: each pixel from row 1 onward is averaged with
// the pixel directly above it; one output per accepted pixel, latency 1.
module line_avg_stream
  import line_avg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COLS   = 8,
  parameter int ROWS   = 16,
  parameter int ROUND  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     sof,
  input  logic [DATA_W-1:0]        data,
  output logic                     valid,
  output logic [DATA_W-1:0]        out,
  output logic                     done,
  output logic [cnt_w(ROWS)-1:0]   row_idx
);

  localparam int COL_W = cnt_w(COLS);
  localparam int ROW_W = cnt_w(ROWS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic [COL_W-1:0]  col_q, col_d, col_eff;
  logic [ROW_W-1:0]  row_q, row_d, row_eff;
  logic              valid_q, valid_d, done_q, done_d;
  logic [DATA_W-1:0] out_q, out_d, rd_data;
  logic [DATA_W:0]   sum;

  // Sum of two pixels halved; half-up adds one before the shift. The
  // DATA_W+1 bit sum plus one still fits, and the halved value fits DATA_W.
  function automatic logic [DATA_W-1:0] avg2(input logic [DATA_W:0] s);
    logic [DATA_W:0] t;
    t = s + (DATA_W+1)'(ROUND == RND_HALF_UP);
    return DATA_W'(t >> 1);
  endfunction

  line_avg_buf #(
    .DATA_W (DATA_W),
    .COLS   (COLS),
    .AW     (COL_W)
  ) u_buf (
    .clk     (clk),
    .we_i    (in_valid),
    .addr_i  (col_eff),
    .wdata_i (data),
    .rdata_o (rd_data)
  );

  always_comb begin
    col_eff = (in_valid && sof) ? '0 : col_q;
    row_eff = (in_valid && sof) ? '0 : row_q;
    sum     = {1'b0, rd_data} + {1'b0, data};
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    out_d   = out_q;
    if (in_valid) begin
      if (col_eff == COL_LAST) begin
        col_d = '0;
        row_d = (row_eff == ROW_LAST) ? '0 : row_eff + ROW_W'(1);
      end else begin
        col_d = col_eff + COL_W'(1);
        row_d = row_eff;
      end
      // Row 0 only seeds the history; every later row produces a pixel.
      if (row_eff != '0) begin
        valid_d = 1'b1;
        out_d   = avg2(sum);
        done_d  = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign valid   = valid_q;
  assign done    = done_q;
  assign out     = out_q;
  assign row_idx = row_q;

endmodule

// File: tb/tb_line_avg_stream.sv
// Scoreboard bench: truncating and half-up 16x8 instances share stimulus,
// plus a small 2x3 4-bit instance; monitors pop expected results on valid.
module tb_line_avg_stream;

  typedef struct {
    logic [7:0] out;
    logic       dn;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0, sof = 1'b0;
  logic [7:0] data = '0;
  logic       in_valid_c = 1'b0, sof_c = 1'b0;
  logic [3:0] data_c = '0;

  logic       valid_a, done_a, valid_b, done_b, valid_c, done_c;
  logic [7:0] out_a, out_b;
  logic [3:0] out_c;
  logic [3:0] row_idx_a, row_idx_b;
  logic [0:0] row_idx_c;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q_a[$], q_b[$], q_c[$];
  exp_t e_a, e_b, e_c;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_avg_stream #(.DATA_W(8), .COLS(8), .ROWS(16), .ROUND(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sof(sof), .data(data),
    .valid(valid_a), .out(out_a), .done(done_a), .row_idx(row_idx_a));

  line_avg_stream #(.DATA_W(8), .COLS(8), .ROWS(16), .ROUND(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sof(sof), .data(data),
    .valid(valid_b), .out(out_b), .done(done_b), .row_idx(row_idx_b));

  line_avg_stream #(.DATA_W(4), .COLS(3), .ROWS(2), .ROUND(0)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid_c), .sof(sof_c), .data(data_c),
    .valid(valid_c), .out(out_c), .done(done_c), .row_idx(row_idx_c));

  function automatic void check(input string nm, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endfunction

  function automatic void unexpected(input string nm, input int act);
    tests++;
    fails++;
    $display("FAIL %s actual=valid out=%0d required=no output", nm, act);
  endfunction

  always @(negedge clk) begin
    if (valid_a) begin
      if (q_a.size() == 0) unexpected("A_extra_valid", out_a);
      else begin
        e_a = q_a.pop_front();
        check("A_out", out_a, e_a.out);
        check("A_done", done_a, e_a.dn);
        check("A_latency", cyc, e_a.cyc);
      end
    end else check("A_done_idle", done_a, 0);
  end

  always @(negedge clk) begin
    if (valid_b) begin
      if (q_b.size() == 0) unexpected("B_extra_valid", out_b);
      else begin
        e_b = q_b.pop_front();
        check("B_out", out_b, e_b.out);
        check("B_done", done_b, e_b.dn);
        check("B_latency", cyc, e_b.cyc);
      end
    end else check("B_done_idle", done_b, 0);
  end

  always @(negedge clk) begin
    if (valid_c) begin
      if (q_c.size() == 0) unexpected("C_extra_valid", out_c);
      else begin
        e_c = q_c.pop_front();
        check("C_out", out_c, e_c.out);
        check("C_done", done_c, e_c.dn);
        check("C_latency", cyc, e_c.cyc);
      end
    end else check("C_done_idle", done_c, 0);
  end

  // One accept on the shared 8-bit stream; ea/eb are the hand-derived
  // truncating and half-up results, pushed only when a row >= 1 pixel.
  task automatic px(input bit s, input int d, input bit has_out,
                    input int ea, input int eb, input bit dn, input bit gap);
    @(posedge clk); #1;
    if (gap && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0; sof = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; sof = s; data = 8'(d);
    if (has_out) begin
      q_a.push_back('{8'(ea), dn, cyc + 1});
      q_b.push_back('{8'(eb), dn, cyc + 1});
    end
  endtask

  task automatic pxc(input bit s, input int d, input bit has_out,
                     input int ev, input bit dn);
    @(posedge clk); #1;
    in_valid_c = 1'b1; sof_c = s; data_c = 4'(d);
    if (has_out) q_c.push_back('{8'(ev), dn, cyc + 1});
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0; sof = 1'b0;
    in_valid_c = 1'b0; sof_c = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_valid", valid_a, 0);
    check("rst_out", out_a, 0);
    check("rst_done", done_a, 0);
    check("rst_row_idx", row_idx_a, 0);
    check("rst_row_idx_c", row_idx_c, 0);
    #1 reset = 1'b0;

    // Rows of 10 then 21: sum 31 -> 15 truncated, 16 half-up.
    for (int c = 0; c < 8; c++) px(c == 0, 10, 0, 0, 0, 0, 0);
    for (int c = 0; c < 8; c++) px(0, 21, 1, 15, 16, 0, 0);
    idle();
    check("row_idx_after_2rows", row_idx_a, 2);

    // Extremes: 255 over 255, 0 under 1, then zeros.
    for (int c = 0; c < 8; c++) px(c == 0, (c == 0) ? 255 : 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 8; c++)
      px(0, (c == 0) ? 255 : (c == 1) ? 1 : 0, 1,
         (c == 0) ? 255 : 0, (c == 0) ? 255 : (c == 1) ? 1 : 0, 0, 0);

    // Two back-to-back frames of pixel 16r+c with gaps; average is 16r+c-8.
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 8; c++)
          px(f == 0 && r == 0 && c == 0, 16*r + c, r != 0,
             16*r + c - 8, 16*r + c - 8, r == 15 && c == 7, 1);
    idle();
    check("row_idx_after_frames", row_idx_a, 0);

    // sof at row 5 col 3 restarts; new row 0 = 100+c, row 1 = 50+c -> 75+c.
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++)
        if (r < 5 || c < 3)
          px(r == 0 && c == 0, 16*r + c, r != 0, 16*r + c - 8, 16*r + c - 8, 0, 0);
    for (int c = 0; c < 8; c++) px(c == 0, 100 + c, 0, 0, 0, 0, 0);
    for (int c = 0; c < 8; c++) px(0, 50 + c, 1, 75 + c, 75 + c, 0, 0);
    idle();
    check("row_idx_after_sof", row_idx_a, 2);

    // Asynchronous reset mid-row 7, while an output is being presented.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (r < 7 || c < 4)
          px(r == 0 && c == 0, 16*r + c, r != 0, 16*r + c - 8, 16*r + c - 8, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; sof = 1'b0;
    check("valid_before_reset", valid_a, 1);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("reset_valid_a", valid_a, 0);
    check("reset_valid_b", valid_b, 0);
    check("reset_done_a", done_a, 0);
    check("reset_row_idx_a", row_idx_a, 0);
    check("reset_row_idx_b", row_idx_b, 0);
    check("reset_out_a", out_a, 0);
    #1 reset = 1'b0;
    // No sof: row 0 = 2c+1, row 1 = 2c+4, sum 4c+5 -> 2c+2 / 2c+3.
    for (int c = 0; c < 8; c++) px(0, 2*c + 1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 8; c++) px(0, 2*c + 4, 1, 2*c + 2, 2*c + 3, 0, 0);
    idle();
    check("row_idx_after_reset_frame", row_idx_a, 2);

    // Small instance: {1,2,3}/{15,14,13} -> 8,8,8; then {0,1,15}/{1,2,15} -> 0,1,15.
    pxc(1, 1, 0, 0, 0);  pxc(0, 2, 0, 0, 0);  pxc(0, 3, 0, 0, 0);
    pxc(0, 15, 1, 8, 0); pxc(0, 14, 1, 8, 0); pxc(0, 13, 1, 8, 1);
    pxc(0, 0, 0, 0, 0);  pxc(0, 1, 0, 0, 0);  pxc(0, 15, 0, 0, 0);
    pxc(0, 1, 1, 0, 0);  pxc(0, 2, 1, 1, 0);  pxc(0, 15, 1, 15, 1);
    idle();
    check("row_idx_c_wrap", row_idx_c, 0);

    for (int i = 0; i < 20 && (q_a.size() + q_b.size() + q_c.size()) != 0; i++)
      @(posedge clk);
    @(negedge clk);
    check("A_pending", q_a.size(), 0);
    check("B_pending", q_b.size(), 0);
    check("C_pending", q_c.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
